serial_subtractor: RTL and testbench

// - Bit-serial N-bit subtractor: computes DIFFERENCE = OPERAND_A - OPERAND_B, one bit per clock, LSB first.
// - Sequential counterpart to the combinational ripple adder in the arithmetic library.
// - Used where area matters more than latency.
// - Start/done handshake; registered results and status flags feed the ALU result mux.
//

---
 rtl/serial_subtractor.sv | 138 +++++++++++++
 tb/tb_serial_subtractor.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor: A - B one bit per clock, LSB first, with a start/done handshake.
// Results and flags are registered and only change on the single FIN cycle that pulses done_o.
module serial_subtractor #(
    parameter  int N     = 8,
    localparam int CNT_W = $clog2(N + 1)
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         start_i,
    input  logic [N-1:0] operand_a_i,
    input  logic [N-1:0] operand_b_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [N-1:0] difference_o,
    output logic         borrow_out_o,
    output logic         zero_o,
    output logic         overflow_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     a_sh_q, a_sh_d;
    logic [N-1:0]     b_sh_q, b_sh_d;
    logic [N-1:0]     res_q, res_d;
    logic             br_q, br_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic [N-1:0]     diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    logic a_bit, b_bit, d_bit, br_nxt;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= S_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_q    <= '0;
            br_q     <= 1'b0;
            cnt_q    <= '0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_q    <= res_d;
            br_q     <= br_d;
            cnt_q    <= cnt_d;
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_d    = res_q;
        br_d     = br_q;
        cnt_d    = cnt_q;
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;

        a_bit  = a_sh_q[0];
        b_bit  = b_sh_q[0];
        d_bit  = a_bit ^ b_bit ^ br_q;
        br_nxt = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    a_sh_d  = operand_a_i;
                    b_sh_d  = operand_b_i;
                    // MSBs are kept aside because the shift registers lose them.
                    a_msb_d = operand_a_i[N-1];
                    b_msb_d = operand_b_i[N-1];
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                res_d  = {d_bit, res_q[N-1:1]};
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                br_d   = br_nxt;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(N - 1)) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                diff_d   = res_q;
                borrow_d = br_q;
                zero_d   = (res_q == '0);
                ovf_d    = (a_msb_q != b_msb_q) && (res_q[N-1] != a_msb_q);
                done_d   = 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy_o       = (state_q == S_RUN);
    assign done_o       = done_q;
    assign difference_o = diff_q;
    assign borrow_out_o = borrow_q;
    assign zero_o       = zero_q;
    assign overflow_o   = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: directed corner cases plus random operands against an arithmetic model.
// All sampling and driving happens on the falling edge, away from the active rising edge.
module tb_serial_subtractor;
    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [N-1:0] a_in, b_in;
    logic         busy_o, done_o, borrow_out_o, zero_o, overflow_o;
    logic [N-1:0] difference_o;

    int n_checks = 0;
    int n_pass   = 0;

    serial_subtractor #(.N(N)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .start_i      (start),
        .operand_a_i  (a_in),
        .operand_b_i  (b_in),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .difference_o (difference_o),
        .borrow_out_o (borrow_out_o),
        .zero_o       (zero_o),
        .overflow_o   (overflow_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks passed %0d of %0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    // Reference: plain modular and signed integer arithmetic.
    function automatic void model(input logic [N-1:0] x, input logic [N-1:0] y,
                                  output logic [N-1:0] d, output logic bo,
                                  output logic z, output logic ov);
        int sx, sy, r;
        d  = N'(x - y);
        bo = (x < y);
        z  = (d == '0);
        sx = int'($signed(x));
        sy = int'($signed(y));
        r  = sx - sy;
        ov = (r > (2 ** (N - 1)) - 1) || (r < -(2 ** (N - 1)));
    endfunction

    function automatic logic [N-1:0] rnd();
        logic [N-1:0] v;
        v = N'($urandom_range(0, (2 ** N) - 1));
        return v;
    endfunction

    // Runs one operation and reports what was observed; the caller judges it.
    task automatic do_op(input logic [N-1:0] x, input logic [N-1:0] y,
                         output logic [N-1:0] d, output logic bo, output logic z, output logic ov,
                         output int lat, output int busy_cnt, output logic held, output logic pulse_ok);
        logic [N-1:0] d0;
        logic         b0, z0, o0;
        @(negedge clk);
        a_in  = x;
        b_in  = y;
        start = 1'b1;
        d0 = difference_o; b0 = borrow_out_o; z0 = zero_o; o0 = overflow_o;
        lat = -1; busy_cnt = 0; held = 1'b1;
        for (int j = 1; j <= 4 * N; j++) begin
            @(negedge clk);
            if (j == 1) begin
                start = 1'b0;
                a_in  = rnd();
                b_in  = rnd();
            end
            if (done_o === 1'b1) begin
                lat = j - 1;
                break;
            end
            if (busy_o === 1'b1) busy_cnt++;
            if (difference_o !== d0 || borrow_out_o !== b0 || zero_o !== z0 || overflow_o !== o0)
                held = 1'b0;
        end
        d = difference_o; bo = borrow_out_o; z = zero_o; ov = overflow_o;
        @(negedge clk);
        pulse_ok = (done_o === 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; a_in = '0; b_in = '0;
        #12;
        n_checks++; if ({busy_o, done_o, borrow_out_o, zero_o, overflow_o} !== 5'b0) $display("FAIL reset_flags: got %b want 00000", {busy_o, done_o, borrow_out_o, zero_o, overflow_o}); else n_pass++;
        n_checks++; if (difference_o !== '0) $display("FAIL reset_diff: got %h want 00", difference_o); else n_pass++;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); @(negedge clk);
        n_checks++; if ({busy_o, done_o} !== 2'b0) $display("FAIL reset_idle: busy/done got %b want 00", {busy_o, done_o}); else n_pass++;
    endtask

    task automatic test_directed();
        logic [N-1:0] ta [7] = '{8'h35, 8'h12, 8'h00, 8'h80, 8'h7F, 8'h55, 8'hA7};
        logic [N-1:0] tb [7] = '{8'h12, 8'h35, 8'h01, 8'h01, 8'hFF, 8'h55, 8'h00};
        logic [N-1:0] td [7] = '{8'h23, 8'hDD, 8'hFF, 8'h7F, 8'h80, 8'h00, 8'hA7};
        logic         tbo[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic         tov[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [N-1:0] d;
        logic bo, z, ov, held, pok;
        int lat, bc;
        for (int i = 0; i < 7; i++) begin
            do_op(ta[i], tb[i], d, bo, z, ov, lat, bc, held, pok);
            n_checks++; if (d !== td[i]) $display("FAIL dir_diff[%0d]: got %h want %h", i, d, td[i]); else n_pass++;
            n_checks++; if (bo !== tbo[i]) $display("FAIL dir_borrow[%0d]: got %b want %b", i, bo, tbo[i]); else n_pass++;
            n_checks++; if (z !== (td[i] == '0)) $display("FAIL dir_zero[%0d]: got %b want %b", i, z, (td[i] == '0)); else n_pass++;
            n_checks++; if (ov !== tov[i]) $display("FAIL dir_ovf[%0d]: got %b want %b", i, ov, tov[i]); else n_pass++;
            n_checks++; if (lat !== N + 1) $display("FAIL dir_latency[%0d]: got %0d want %0d", i, lat, N + 1); else n_pass++;
            n_checks++; if (bc !== N) $display("FAIL dir_busy_cycles[%0d]: got %0d want %0d", i, bc, N); else n_pass++;
            n_checks++; if (held !== 1'b1) $display("FAIL dir_hold[%0d]: outputs changed before done", i); else n_pass++;
            n_checks++; if (pok !== 1'b1) $display("FAIL dir_done_pulse[%0d]: done high for more than one cycle", i); else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [N-1:0] x, y, d, ed;
        logic bo, z, ov, ebo, ez, eov, held, pok;
        int lat, bc;
        for (int i = 0; i < 40; i++) begin
            x = rnd(); y = rnd();
            if (i % 10 == 0) y = x;
            model(x, y, ed, ebo, ez, eov);
            do_op(x, y, d, bo, z, ov, lat, bc, held, pok);
            n_checks++; if (d !== ed) $display("FAIL rnd_diff %h-%h: got %h want %h", x, y, d, ed); else n_pass++;
            n_checks++; if ({bo, z, ov} !== {ebo, ez, eov}) $display("FAIL rnd_flags %h-%h: borrow/zero/ovf got %b want %b", x, y, {bo, z, ov}, {ebo, ez, eov}); else n_pass++;
            n_checks++; if (lat !== N + 1) $display("FAIL rnd_latency %h-%h: got %0d want %0d", x, y, lat, N + 1); else n_pass++;
            n_checks++; if (held !== 1'b1 || pok !== 1'b1) $display("FAIL rnd_hold_pulse %h-%h: held %b pulse_ok %b want 1 1", x, y, held, pok); else n_pass++;
        end
    endtask

    task automatic test_start_held();
        logic [N-1:0] x0, y0, x1, y1, nx, ny, ed, ed2;
        logic ebo, ez, eov, ebo2, ez2, eov2;
        int first_j, second_j, done_cnt;
        x0 = rnd(); y0 = rnd();
        x1 = '0; y1 = '0;
        first_j = -1; second_j = -1; done_cnt = 0;
        model(x0, y0, ed, ebo, ez, eov);
        @(negedge clk);
        a_in = x0; b_in = y0; start = 1'b1;
        for (int j = 1; j <= 2 * N + 4; j++) begin
            @(negedge clk);
            if (done_o === 1'b1) begin
                done_cnt++;
                if (first_j < 0) begin
                    first_j = j;
                    n_checks++; if ({difference_o, borrow_out_o, zero_o, overflow_o} !== {ed, ebo, ez, eov})
                        $display("FAIL held_first_result: got %h/%b%b%b want %h/%b%b%b", difference_o, borrow_out_o, zero_o, overflow_o, ed, ebo, ez, eov);
                    else n_pass++;
                end else begin
                    second_j = j;
                    model(x1, y1, ed2, ebo2, ez2, eov2);
                    n_checks++; if ({difference_o, borrow_out_o, zero_o, overflow_o} !== {ed2, ebo2, ez2, eov2})
                        $display("FAIL held_second_result: got %h/%b%b%b want %h/%b%b%b", difference_o, borrow_out_o, zero_o, overflow_o, ed2, ebo2, ez2, eov2);
                    else n_pass++;
                end
            end
            nx = rnd(); ny = rnd();
            a_in = nx; b_in = ny;
            if (j == N + 2) begin x1 = nx; y1 = ny; end
            if (j == 2 * N + 4) start = 1'b0;
        end
        n_checks++; if (first_j !== N + 2) $display("FAIL held_first_done: at step %0d want %0d", first_j, N + 2); else n_pass++;
        n_checks++; if (second_j !== 2 * N + 4) $display("FAIL held_second_done: at step %0d want %0d", second_j, 2 * N + 4); else n_pass++;
        n_checks++; if (done_cnt !== 2) $display("FAIL held_done_count: got %0d want 2", done_cnt); else n_pass++;
        done_cnt = 0;
        for (int j = 0; j < 2 * N; j++) begin
            @(negedge clk);
            if (done_o === 1'b1 || busy_o === 1'b1) done_cnt++;
        end
        n_checks++; if (done_cnt !== 0) $display("FAIL held_quiet_after: activity on %0d cycles want 0", done_cnt); else n_pass++;
    endtask

    task automatic test_reset_abort();
        logic [N-1:0] d, x, y, ed;
        logic bo, z, ov, ebo, ez, eov, held, pok;
        int lat, bc, act;
        do_op(8'h35, 8'h12, d, bo, z, ov, lat, bc, held, pok);
        @(negedge clk);
        a_in = 8'h12; b_in = 8'h35; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk); @(negedge clk); @(negedge clk);
        n_checks++; if (busy_o !== 1'b1) $display("FAIL abort_busy_before: got %b want 1", busy_o); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++; if (difference_o !== '0) $display("FAIL abort_diff: got %h want 00", difference_o); else n_pass++;
        n_checks++; if ({busy_o, done_o, borrow_out_o, zero_o, overflow_o} !== 5'b0) $display("FAIL abort_flags: got %b want 00000", {busy_o, done_o, borrow_out_o, zero_o, overflow_o}); else n_pass++;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        act = 0;
        for (int j = 0; j < 2 * N; j++) begin
            @(negedge clk);
            if (done_o === 1'b1 || busy_o === 1'b1) act++;
        end
        n_checks++; if (act !== 0) $display("FAIL abort_no_done: activity on %0d cycles want 0", act); else n_pass++;
        x = rnd(); y = rnd();
        model(x, y, ed, ebo, ez, eov);
        do_op(x, y, d, bo, z, ov, lat, bc, held, pok);
        n_checks++; if ({d, bo, z, ov} !== {ed, ebo, ez, eov}) $display("FAIL abort_fresh_op %h-%h: got %h/%b%b%b want %h/%b%b%b", x, y, d, bo, z, ov, ed, ebo, ez, eov); else n_pass++;
        n_checks++; if (lat !== N + 1) $display("FAIL abort_fresh_latency: got %0d want %0d", lat, N + 1); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_start_held();
        test_reset_abort();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
